exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM pipeline; consumes the ID/EXE register outputs.
//  Generates Val2, runs the ALU and computes the branch target. Owns the NZCV status register.
//  Holds the EXE/MEM pipeline register that feeds the memory stage.
//  Status register output returns to ID for condition checking; branch outputs return to IF.
// PARAMETERS
//  DW      32  datapath width (ARM word; only 32 supported)
//  RW      4   register-index width
// PORTS
//  clk            in   1   pipeline clock, all flops on posedge
//  rst            in   1   asynchronous, active-low reset
//  freeze         in   1   hazard stall; holds EXE/MEM reg and status reg
//  wb_en_in       in   1   write-back enable from ID/EXE reg
//  mem_r_en_in    in   1   load
//  mem_w_en_in    in   1   store
//  s_update       in   1   instruction S bit: update NZCV
//  branch         in   1   instruction is a taken branch (condition already passed in ID)
//  exe_cmd        in   4   ALU command
//  val_rn         in   DW  operand 1
//  val_rm         in   DW  Rm value / store data
//  pc             in   DW  PC+4 of this instruction
//  imm            in   1   I bit: Val2 from rotated immediate
//  shift_operand  in   12  instruction bits [11:0]
//  signed_imm24   in   24  branch offset (words)
//  dest_in        in   RW  Rd
//  branch_taken   out  1   = branch (combinational)
//  branch_address out  DW  pc + (sext(signed_imm24) << 2) (combinational)
//  status_reg     out  4   {N,Z,C,V}
//  wb_en, mem_r_en, mem_w_en  out 1  registered controls
//  alu_res        out  DW  registered ALU result / memory address
//  val_rm_out     out  DW  registered store data
//  dest           out  RW  registered Rd
// BEHAVIOUR
//  - rst=0 (any time, async): all registered outputs and status_reg -> 0. Mid-instruction state discarded.
//  - Latency: ALU result visible on alu_res one posedge after inputs presented.
//  - Val2 generation:
//     - mem op (mem_r_en_in|mem_w_en_in): zero-extended shift_operand[11:0].
//     - imm=1: {24'b0,so[7:0]} ROR (2*so[11:8]).
//     - else: val_rm shifted by so[11:7] with type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Amount 0 = no shift.
//  - exe_cmd:
//     - 0001 MOV Val2; 1001 MVN ~Val2
//     - 0010 ADD Rn+Val2; 0011 ADC Rn+Val2+C
//     - 0100 SUB/CMP Rn-Val2; 0101 SBC Rn-Val2-~C
//     - 0110 AND/TST; 0111 ORR; 1000 EOR
//     - others -> 0
//     - LDR/STR use 0010.
//  - Flags:
//     - N=res[31], Z=(res==0).
//     - Add: C = carry-out; V = (a31==b31)&&(r31!=a31).
//     - Sub: C = NOT borrow (Rn>=Val2+~C unsigned); V = (a31!=b31)&&(r31!=a31).
//     - Logic/move: C,V keep old value.
//     - Arithmetic uses a 33-bit sum.
//  - Status reg loads new NZCV on posedge iff s_update && !freeze. Otherwise holds.
//  - ADC/SBC read the currently registered C.
//  - freeze=1: EXE/MEM reg and status reg hold; branch outputs still combinational.
//  - freeze=0: EXE/MEM reg captures every cycle, including bubbles (bubble = all enables 0).
//  - Branch: branch_taken=branch; branch_address independent of exe_cmd. No flag update unless s_update.
//  - Offset wrap: 32-bit modular add; negative offsets sign-extended from bit 23.
// STRUCTURE
//  - Package arm_pkg: exe_cmd localparams, shift-type codes, NZCV bit indices (N=3,Z=2,C=1,V=0).
//  - Sub-module val2_gen: combinational Val2 generator.
//  - ALU, status reg, branch adder and EXE/MEM reg stay in exe_stage.
// TESTING
//  - Reset, EXE/MEM reg: drive rst=0 mid-stream.
//     -> alu_res=0, wb_en=0, status_reg=0000 immediately, without a clock edge.
//  - ADD with S: Rn=0x7FFFFFFF, imm so=0x001, exe_cmd=0010, s_update=1.
//     -> alu_res=0x80000000 next edge; status=1001 (N,V).
//  - SUB with S: Rn=5, Rm=5, LSL 0, exe_cmd=0100, s_update=1.
//     -> alu_res=0; status=0110 (Z,C).
//  - Rotated imm and C preserve: so=0x4FF (0xFF ROR 8), MOV, s_update=1, prior C=1.
//     -> alu_res=0xFF000000; status=1010.
//  - Branch: pc=0x100, imm24=0xFFFFFE, branch=1.
//     -> branch_taken=1, branch_address=0x0F8 same cycle.
//  - Freeze: freeze=1 with ADD s_update=1.
//     -> alu_res, dest, status_reg unchanged across edges.
//     -> Release freeze: captured next edge.

Source files
------------

// File: rtl/arm_pkg.sv
// ============================================================================
// arm_pkg : shared ALU command codes, shift types and NZCV bit indices
// Rev 1.0
// ============================================================================
`default_nettype none

package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] d;
    d = {v, v} >> amt;
    return d[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/val2_gen.sv
// ============================================================================
// val2_gen : second-operand generator (mem offset, rotated imm, shifted Rm)
// Rev 1.0
// ============================================================================
`default_nettype none

module val2_gen
  import arm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          mem_op,
  input  logic          imm,
  input  logic [11:0]   shift_operand,
  input  logic [DW-1:0] val_rm,
  output logic [DW-1:0] val2
);

  logic [4:0] amt;
  assign amt = shift_operand[11:7];

  // A zero shift amount passes Rm through unchanged for every shift type.
  always_comb begin
    val2 = '0;
    if (mem_op) begin
      val2 = {{(DW-12){1'b0}}, shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << amt;
        SH_LSR:  val2 = val_rm >> amt;
        SH_ASR:  val2 = $signed(val_rm) >>> amt;
        default: val2 = ror32(val_rm, amt);
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
// exe_stage : ARM execute stage - ALU, NZCV register, branch adder, EXE/MEM reg
// Rev 1.0
// ============================================================================
`default_nettype none

module exe_stage
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          wb_en_in,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  input  logic          s_update,
  input  logic          branch,
  input  logic [3:0]    exe_cmd,
  input  logic [DW-1:0] val_rn,
  input  logic [DW-1:0] val_rm,
  input  logic [DW-1:0] pc,
  input  logic          imm,
  input  logic [11:0]   shift_operand,
  input  logic [23:0]   signed_imm24,
  input  logic [RW-1:0] dest_in,
  output logic          branch_taken,
  output logic [DW-1:0] branch_address,
  output logic [3:0]    status_reg,
  output logic          wb_en,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic [DW-1:0] alu_res,
  output logic [DW-1:0] val_rm_out,
  output logic [RW-1:0] dest
);

  logic [DW-1:0] val2;
  logic [DW:0]   sum;
  logic [DW-1:0] res;
  logic          carry_in;
  logic          c_new;
  logic          v_new;
  logic [3:0]    nzcv;

  val2_gen #(.DW(DW)) u_val2_gen (
    .mem_op        (mem_r_en_in | mem_w_en_in),
    .imm           (imm),
    .shift_operand (shift_operand),
    .val_rm        (val_rm),
    .val2          (val2)
  );

  // Subtraction is Rn + ~Val2 + cin, so the carry-out is the ARM "not borrow".
  always_comb begin
    sum      = '0;
    res      = '0;
    carry_in = 1'b0;
    c_new    = status_reg[FLAG_C];
    v_new    = status_reg[FLAG_V];
    case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        carry_in = (exe_cmd == CMD_ADC) & status_reg[FLAG_C];
        sum      = {1'b0, val_rn} + {1'b0, val2} + {{DW{1'b0}}, carry_in};
        res      = sum[DW-1:0];
        c_new    = sum[DW];
        v_new    = (val_rn[DW-1] == val2[DW-1]) && (res[DW-1] != val_rn[DW-1]);
      end
      CMD_SUB, CMD_SBC: begin
        carry_in = (exe_cmd == CMD_SUB) | status_reg[FLAG_C];
        sum      = {1'b0, val_rn} + {1'b0, ~val2} + {{DW{1'b0}}, carry_in};
        res      = sum[DW-1:0];
        c_new    = sum[DW];
        v_new    = (val_rn[DW-1] != val2[DW-1]) && (res[DW-1] != val_rn[DW-1]);
      end
      CMD_AND: res = val_rn & val2;
      CMD_ORR: res = val_rn | val2;
      CMD_EOR: res = val_rn ^ val2;
      default: res = '0;
    endcase
    nzcv = {res[DW-1], (res == '0), c_new, v_new};
  end

  assign branch_taken   = branch;
  assign branch_address = pc + {{(DW-26){signed_imm24[23]}}, signed_imm24, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_reg <= '0;
    end else if (s_update && !freeze) begin
      status_reg <= nzcv;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      alu_res    <= '0;
      val_rm_out <= '0;
      dest       <= '0;
    end else if (!freeze) begin
      wb_en      <= wb_en_in;
      mem_r_en   <= mem_r_en_in;
      mem_w_en   <= mem_w_en_in;
      alu_res    <= res;
      val_rm_out <= val_rm;
      dest       <= dest_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ============================================================================
// tb_exe_stage : directed + randomized check of exe_stage against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exe_stage;

  logic        clk;
  logic        rst_n;
  logic        freeze, wb_en_in, mem_r_en_in, mem_w_en_in, s_update, branch, imm;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn, val_rm, pc;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm24;
  logic [3:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status_reg;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm_out;
  logic [3:0]  dest;

  exe_stage #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst(rst_n), .freeze(freeze), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .s_update(s_update),
    .branch(branch), .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .pc(pc),
    .imm(imm), .shift_operand(shift_operand), .signed_imm24(signed_imm24),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_address(branch_address),
    .status_reg(status_reg), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm_out(val_rm_out), .dest(dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference state
  logic [3:0]  m_status;
  logic [31:0] m_alu, m_rm;
  logic [3:0]  m_dest;
  logic        m_wb, m_mr, m_mw;

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    longint unsigned x;
    x = v;
    return 32'(((x >> n) | (x << (32 - n))) & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_val2();
    int amt;
    int s;
    if (mem_r_en_in || mem_w_en_in) return {20'h0, shift_operand};
    if (imm) return rotr({24'h0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
    amt = int'(shift_operand[11:7]);
    s   = val_rm;
    case (shift_operand[6:5])
      2'd0:    return val_rm << amt;
      2'd1:    return val_rm >> amt;
      2'd2:    return 32'(s >>> amt);
      default: return rotr(val_rm, amt);
    endcase
  endfunction

  task automatic ref_alu(output logic [31:0] r, output logic [3:0] f);
    logic [31:0]     b;
    longint unsigned ua, ub, w;
    longint          sa, sb, sv;
    int              ia, ib;
    logic            c, v, cin;
    b  = ref_val2();
    ua = val_rn; ub = b;
    ia = val_rn; ib = b;
    sa = ia;     sb = ib;
    c  = m_status[1];
    v  = m_status[0];
    r  = 32'h0;
    case (exe_cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        cin = (exe_cmd == 4'd3) ? c : 1'b0;
        w   = ua + ub + longint'(cin);
        r   = w[31:0];
        c   = (w >= 64'h1_0000_0000);
        sv  = sa + sb + longint'(cin);
        v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin = (exe_cmd == 4'd5) ? ~c : 1'b0;  // borrow
        c   = (ua >= ub + longint'(cin));
        w   = ua - ub - longint'(cin);
        r   = w[31:0];
        sv  = sa - sb - longint'(cin);
        v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd6: r = val_rn & b;
      4'd7: r = val_rn | b;
      4'd8: r = val_rn ^ b;
      default: r = 32'h0;
    endcase
    f = {r[31], r == 32'h0, c, v};
  endtask

  function automatic logic [31:0] ref_branch();
    longint off;
    off = signed_imm24;
    if (off >= 64'sd8388608) off = off - 64'sd16777216;
    return 32'((longint'(pc) + off * 4) & 64'hFFFF_FFFF);
  endfunction

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic run_cycle();
    logic [31:0] r;
    logic [3:0]  f;
    ref_alu(r, f);
    #1;
    check("br_taken", {31'h0, branch_taken}, {31'h0, branch});
    check("br_addr", branch_address, ref_branch());
    @(posedge clk);
    #1;
    if (!freeze) begin
      m_alu = r; m_rm = val_rm; m_dest = dest_in;
      m_wb = wb_en_in; m_mr = mem_r_en_in; m_mw = mem_w_en_in;
      if (s_update) m_status = f;
    end
    check("alu_res", alu_res, m_alu);
    check("status", {28'h0, status_reg}, {28'h0, m_status});
    check("rm_out", val_rm_out, m_rm);
    check("dest", {28'h0, dest}, {28'h0, m_dest});
    check("ctrl", {29'h0, wb_en, mem_r_en, mem_w_en}, {29'h0, m_wb, m_mr, m_mw});
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_update = 0;
    branch = 0; imm = 0; exe_cmd = 4'h0; val_rn = 0; val_rm = 0; pc = 0;
    shift_operand = 12'h0; signed_imm24 = 24'h0; dest_in = 4'h0;
  endtask

  task automatic model_reset();
    m_status = 4'h0; m_alu = 0; m_rm = 0; m_dest = 0; m_wb = 0; m_mr = 0; m_mw = 0;
  endtask

  logic [31:0] saved_alu;
  logic [3:0]  saved_status;

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu", alu_res, 32'h0);
    check("rst_status", {28'h0, status_reg}, 32'h0);
    rst_n = 1'b1;

    // ADD with S producing signed overflow
    exe_cmd = 4'b0010; val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001;
    s_update = 1; wb_en_in = 1; dest_in = 4'd3;
    run_cycle();
    check("add_res", alu_res, 32'h8000_0000);
    check("add_nzcv", {28'h0, status_reg}, 32'h9);

    // SUB equal operands
    exe_cmd = 4'b0100; val_rn = 5; val_rm = 5; imm = 0; shift_operand = 12'h000;
    run_cycle();
    check("sub_res", alu_res, 32'h0);
    check("sub_nzcv", {28'h0, status_reg}, 32'h6);

    // MOV rotated immediate keeps C
    exe_cmd = 4'b0001; imm = 1; shift_operand = 12'h4FF;
    run_cycle();
    check("mov_res", alu_res, 32'hFF00_0000);
    check("mov_nzcv", {28'h0, status_reg}, 32'hA);

    // Branch backwards
    clear_inputs();
    pc = 32'h100; signed_imm24 = 24'hFFFFFE; branch = 1;
    #1;
    check("br_dir_taken", {31'h0, branch_taken}, 32'h1);
    check("br_dir_addr", branch_address, 32'h0F8);
    run_cycle();

    // Freeze holds everything, release captures
    saved_alu = alu_res; saved_status = status_reg;
    clear_inputs();
    freeze = 1; exe_cmd = 4'b0010; val_rn = 32'h1234; val_rm = 32'h1;
    s_update = 1; dest_in = 4'd9; wb_en_in = 1;
    run_cycle();
    run_cycle();
    check("frz_alu", alu_res, saved_alu);
    check("frz_status", {28'h0, status_reg}, {28'h0, saved_status});
    freeze = 0;
    run_cycle();
    check("unfrz_alu", alu_res, 32'h1235);
    check("unfrz_dest", {28'h0, dest}, 32'd9);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("arst_alu", alu_res, 32'h0);
    check("arst_wb", {31'h0, wb_en}, 32'h0);
    check("arst_status", {28'h0, status_reg}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      freeze        = ($urandom_range(0, 4) == 0);
      s_update      = $urandom_range(0, 1);
      branch        = $urandom_range(0, 1);
      wb_en_in      = $urandom_range(0, 1);
      mem_r_en_in   = ($urandom_range(0, 5) == 0);
      mem_w_en_in   = !mem_r_en_in && ($urandom_range(0, 5) == 0);
      imm           = $urandom_range(0, 1);
      exe_cmd       = 4'($urandom_range(0, 15));
      val_rn        = (i % 7 == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      val_rm        = $urandom;
      pc            = $urandom;
      shift_operand = 12'($urandom);
      signed_imm24  = 24'($urandom);
      dest_in       = 4'($urandom);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
